// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM decoder: FSM state encoding,
// counter width, stuck-level codes and saturating arithmetic helpers.
package pwm_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [1:0] STUCK_NONE = 2'b00;
  localparam logic [1:0] STUCK_LOW  = 2'b01;
  localparam logic [1:0] STUCK_HIGH = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ZERO = 16'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 16'd1;
  localparam logic [CNT_W-1:0] CNT_MAX  = 16'hFFFF;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    logic [CNT_W-1:0] r;
    s = {1'b0, a} + {1'b0, b};
    if (s[CNT_W]) begin
      r = CNT_MAX;
    end else begin
      r = s[CNT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // metastability filter: first flop may go metastable, second settles it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pwm_decoder.sv
// Measures high time and period of an asynchronous PWM input, and reports
// inputs that stop toggling as stuck-low / stuck-high.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int MAX_COUNT = 255,
  parameter int TIMEOUT   = 2 * (MAX_COUNT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pwm_in,
  output logic [CNT_W-1:0] o_duty,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic [1:0]       o_stuck
);

  localparam logic [CNT_W-1:0] TO_VAL    = (TIMEOUT >= 65535) ? CNT_MAX : CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] DUTY_HIGH = CNT_W'(MAX_COUNT + 1);

  logic             w_sync;
  logic             w_rise;
  logic             w_fall;
  logic             w_primed;
  logic             r_prev;
  logic [1:0]       r_fill;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] w_hi_nxt;
  logic [CNT_W-1:0] r_lo_cnt;
  logic [CNT_W-1:0] w_lo_nxt;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] w_duty_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [1:0]       r_stuck;
  logic [1:0]       w_stuck_nxt;
  logic             r_reported;
  logic             w_rep_nxt;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pwm_in),
    .o_q     (w_sync)
  );

  // previous synchronized sample, plus a fill count so edges are only trusted
  // once every pipeline flop holds a real sample rather than its reset value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
      r_fill <= 2'd0;
    end else begin
      r_prev <= w_sync;
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end else begin
        r_fill <= r_fill;
      end
    end
  end

  assign w_primed = (r_fill == 2'd3);
  assign w_rise   = w_primed & w_sync & ~r_prev;
  assign w_fall   = w_primed & ~w_sync & r_prev;

  // state, counter and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= SYNC;
      r_hi_cnt   <= CNT_ZERO;
      r_lo_cnt   <= CNT_ZERO;
      r_duty     <= CNT_ZERO;
      r_period   <= CNT_ZERO;
      r_valid    <= 1'b0;
      r_stuck    <= STUCK_NONE;
      r_reported <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hi_cnt   <= w_hi_nxt;
      r_lo_cnt   <= w_lo_nxt;
      r_duty     <= w_duty_nxt;
      r_period   <= w_period_nxt;
      r_valid    <= w_valid_nxt;
      r_stuck    <= w_stuck_nxt;
      r_reported <= w_rep_nxt;
    end
  end

  // next-state, counting and measurement/timeout reporting
  always_comb begin
    w_state_nxt  = r_state;
    w_hi_nxt     = r_hi_cnt;
    w_lo_nxt     = r_lo_cnt;
    w_duty_nxt   = r_duty;
    w_period_nxt = r_period;
    w_valid_nxt  = 1'b0;
    w_stuck_nxt  = r_stuck;
    w_rep_nxt    = r_reported;
    case (r_state)
      SYNC: begin
        if (!w_primed) begin
          w_lo_nxt = CNT_ZERO;
        end else if (w_rise) begin
          w_state_nxt = HIGH;
          w_hi_nxt    = CNT_ONE;
          w_lo_nxt    = CNT_ZERO;
          w_rep_nxt   = 1'b0;
        end else if (w_sync) begin
          w_lo_nxt = CNT_ZERO;
        end else begin
          // lo_cnt doubles as the idle counter while waiting for lock
          w_lo_nxt = sat_inc(r_lo_cnt);
          if ((r_lo_cnt >= TO_VAL) && !r_reported) begin
            w_duty_nxt   = CNT_ZERO;
            w_period_nxt = CNT_ZERO;
            w_stuck_nxt  = STUCK_LOW;
            w_valid_nxt  = 1'b1;
            w_rep_nxt    = 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
          end
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_state_nxt = LOW;
          w_lo_nxt    = CNT_ONE;
          w_rep_nxt   = 1'b0;
        end else begin
          w_hi_nxt = sat_inc(r_hi_cnt);
          if ((r_hi_cnt >= TO_VAL) && !r_reported) begin
            w_duty_nxt   = DUTY_HIGH;
            w_period_nxt = CNT_ZERO;
            w_stuck_nxt  = STUCK_HIGH;
            w_valid_nxt  = 1'b1;
            w_rep_nxt    = 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
          end
        end
      end
      LOW: begin
        if (w_rise) begin
          // a rise that ends a stuck-low spell starts fresh without measuring
          if (!r_reported) begin
            w_duty_nxt   = r_hi_cnt;
            w_period_nxt = sat_add(r_hi_cnt, r_lo_cnt);
            w_stuck_nxt  = STUCK_NONE;
            w_valid_nxt  = 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
          end
          w_state_nxt = HIGH;
          w_hi_nxt    = CNT_ONE;
          w_lo_nxt    = CNT_ZERO;
          w_rep_nxt   = 1'b0;
        end else begin
          w_lo_nxt = sat_inc(r_lo_cnt);
          if ((r_lo_cnt >= TO_VAL) && !r_reported) begin
            w_duty_nxt   = CNT_ZERO;
            w_period_nxt = CNT_ZERO;
            w_stuck_nxt  = STUCK_LOW;
            w_valid_nxt  = 1'b1;
            w_rep_nxt    = 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = SYNC;
        w_hi_nxt    = CNT_ZERO;
        w_lo_nxt    = CNT_ZERO;
        w_rep_nxt   = 1'b0;
      end
    endcase
  end

  assign o_duty   = r_duty;
  assign o_period = r_period;
  assign o_valid  = r_valid;
  assign o_stuck  = r_stuck;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: reset, steady measurement, duty sweep,
// stuck-low/high timeouts, mid-measurement reset and sub-cycle input phase.
module tb_pwm_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] duty;
  logic [15:0] period;
  logic        valid;
  logic [1:0]  stuck;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] q_duty[$];
  logic [15:0] q_period[$];
  logic [1:0]  q_stuck[$];
  time         q_t[$];

  pwm_decoder #(.MAX_COUNT(255), .TIMEOUT(512)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_pwm_in (pwm_in),
    .o_duty   (duty),
    .o_period (period),
    .o_valid  (valid),
    .o_stuck  (stuck)
  );

  always #5 clk = ~clk;

  // log every valid pulse, sampled on the falling edge
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      q_duty.push_back(duty);
      q_period.push_back(period);
      q_stuck.push_back(stuck);
      q_t.push_back($time);
    end
  end

  task automatic clear_q();
    @(posedge clk);
    q_duty.delete();
    q_period.delete();
    q_stuck.delete();
    q_t.delete();
  endtask

  task automatic hold(input logic lvl, input int n, output time t0);
    t0 = 0;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      if (s == 0) t0 = $time;
      pwm_in = lvl;
    end
  endtask

  task automatic pwm_cycles(input int p, input int h, input int n, output time t0);
    t0 = 0;
    for (int c = 0; c < n; c++) begin
      for (int s = 0; s < p; s++) begin
        @(negedge clk);
        if (c == 0 && s == 0) t0 = $time;
        pwm_in = (s < h);
      end
    end
  endtask

  task automatic test_reset();
    time t0;
    rst_n = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (duty !== 16'd0) begin n_err++; $display("FAIL reset.duty got=%0d exp=0", duty); end
    n_vec++; if (period !== 16'd0) begin n_err++; $display("FAIL reset.period got=%0d exp=0", period); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset.valid got=%0b exp=0", valid); end
    n_vec++; if (stuck !== 2'b00) begin n_err++; $display("FAIL reset.stuck got=%0b exp=00", stuck); end
    rst_n = 1'b1;
    clear_q();
    // input idle low from reset: a single stuck-low report from SYNC
    hold(1'b0, 560, t0);
    n_vec++; if (q_duty.size() != 1) begin n_err++; $display("FAIL sync_idle.count got=%0d exp=1", q_duty.size()); end
    if (q_duty.size() >= 1) begin
      n_vec++; if (q_stuck[0] !== 2'b01) begin n_err++; $display("FAIL sync_idle.stuck got=%0b exp=01", q_stuck[0]); end
      n_vec++; if (q_duty[0] !== 16'd0) begin n_err++; $display("FAIL sync_idle.duty got=%0d exp=0", q_duty[0]); end
      n_vec++; if (q_period[0] !== 16'd0) begin n_err++; $display("FAIL sync_idle.period got=%0d exp=0", q_period[0]); end
    end
  endtask

  task automatic test_basic();
    time t0;
    clear_q();
    pwm_cycles(256, 64, 5, t0);
    n_vec++; if (q_duty.size() != 4) begin n_err++; $display("FAIL basic.count got=%0d exp=4", q_duty.size()); end
    for (int i = 0; i < q_duty.size(); i++) begin
      n_vec++; if (q_duty[i] !== 16'd64) begin n_err++; $display("FAIL basic.duty[%0d] got=%0d exp=64", i, q_duty[i]); end
      n_vec++; if (q_period[i] !== 16'd256) begin n_err++; $display("FAIL basic.period[%0d] got=%0d exp=256", i, q_period[i]); end
      n_vec++; if (q_stuck[i] !== 2'b00) begin n_err++; $display("FAIL basic.stuck[%0d] got=%0b exp=00", i, q_stuck[i]); end
    end
    if (q_t.size() >= 1) begin
      n_vec++; if (q_t[0] != t0 + 2560 + 30) begin n_err++; $display("FAIL basic.latency got=%0t exp=%0t", q_t[0], t0 + 2560 + 30); end
    end
  endtask

  task automatic test_sweep();
    time t0;
    int d;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 1 : ((k == 1) ? 128 : 255);
      clear_q();
      pwm_cycles(256, d, 3, t0);
      n_vec++; if (q_duty.size() != 3) begin n_err++; $display("FAIL sweep%0d.count got=%0d exp=3", d, q_duty.size()); end
      if (q_duty.size() >= 2) begin
        n_vec++; if (q_duty[1] !== 16'(d)) begin n_err++; $display("FAIL sweep%0d.duty got=%0d exp=%0d", d, q_duty[1], d); end
        n_vec++; if (q_period[1] !== 16'd256) begin n_err++; $display("FAIL sweep%0d.period got=%0d exp=256", d, q_period[1]); end
      end
    end
  endtask

  task automatic test_stuck_low();
    time tr;
    time tf;
    clear_q();
    hold(1'b1, 64, tr);
    hold(1'b0, 600, tf);
    // first entry is the measurement closed by the rise; second is the timeout
    n_vec++; if (q_duty.size() != 2) begin n_err++; $display("FAIL stuck_low.count got=%0d exp=2", q_duty.size()); end
    if (q_duty.size() >= 2) begin
      n_vec++; if (q_stuck[1] !== 2'b01) begin n_err++; $display("FAIL stuck_low.code got=%0b exp=01", q_stuck[1]); end
      n_vec++; if (q_duty[1] !== 16'd0) begin n_err++; $display("FAIL stuck_low.duty got=%0d exp=0", q_duty[1]); end
      n_vec++; if (q_period[1] !== 16'd0) begin n_err++; $display("FAIL stuck_low.period got=%0d exp=0", q_period[1]); end
      n_vec++; if (q_t[1] != tf + 5150) begin n_err++; $display("FAIL stuck_low.time got=%0t exp=%0t", q_t[1], tf + 5150); end
    end
  endtask

  task automatic test_stuck_high();
    time tr;
    clear_q();
    // rise after stuck-low must not report a measurement
    hold(1'b1, 600, tr);
    n_vec++; if (q_duty.size() != 1) begin n_err++; $display("FAIL stuck_high.count got=%0d exp=1", q_duty.size()); end
    if (q_duty.size() >= 1) begin
      n_vec++; if (q_stuck[0] !== 2'b10) begin n_err++; $display("FAIL stuck_high.code got=%0b exp=10", q_stuck[0]); end
      n_vec++; if (q_duty[0] !== 16'd256) begin n_err++; $display("FAIL stuck_high.duty got=%0d exp=256", q_duty[0]); end
      n_vec++; if (q_period[0] !== 16'd0) begin n_err++; $display("FAIL stuck_high.period got=%0d exp=0", q_period[0]); end
      n_vec++; if (q_t[0] != tr + 5150) begin n_err++; $display("FAIL stuck_high.time got=%0t exp=%0t", q_t[0], tr + 5150); end
    end
    clear_q();
    pwm_cycles(256, 64, 3, tr);
    n_vec++; if (q_duty.size() != 2) begin n_err++; $display("FAIL recover.count got=%0d exp=2", q_duty.size()); end
    if (q_duty.size() >= 2) begin
      n_vec++; if (q_duty[0] !== 16'd664) begin n_err++; $display("FAIL recover.long_duty got=%0d exp=664", q_duty[0]); end
      n_vec++; if (q_period[0] !== 16'd856) begin n_err++; $display("FAIL recover.long_period got=%0d exp=856", q_period[0]); end
      n_vec++; if (q_stuck[0] !== 2'b00) begin n_err++; $display("FAIL recover.stuck got=%0b exp=00", q_stuck[0]); end
      n_vec++; if (q_duty[1] !== 16'd64) begin n_err++; $display("FAIL recover.duty got=%0d exp=64", q_duty[1]); end
      n_vec++; if (q_period[1] !== 16'd256) begin n_err++; $display("FAIL recover.period got=%0d exp=256", q_period[1]); end
    end
  endtask

  task automatic test_reset_mid();
    time t0;
    hold(1'b1, 30, t0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (duty !== 16'd0) begin n_err++; $display("FAIL rst_mid.duty got=%0d exp=0", duty); end
    n_vec++; if (period !== 16'd0) begin n_err++; $display("FAIL rst_mid.period got=%0d exp=0", period); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_mid.valid got=%0b exp=0", valid); end
    n_vec++; if (stuck !== 2'b00) begin n_err++; $display("FAIL rst_mid.stuck got=%0b exp=00", stuck); end
    clear_q();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // finish the interrupted high phase, then two clean periods
    hold(1'b1, 34, t0);
    hold(1'b0, 192, t0);
    pwm_cycles(256, 64, 2, t0);
    n_vec++; if (q_duty.size() != 1) begin n_err++; $display("FAIL rst_mid.count got=%0d exp=1", q_duty.size()); end
    if (q_duty.size() >= 1) begin
      n_vec++; if (q_duty[0] !== 16'd64) begin n_err++; $display("FAIL rst_mid.new_duty got=%0d exp=64", q_duty[0]); end
      n_vec++; if (q_period[0] !== 16'd256) begin n_err++; $display("FAIL rst_mid.new_period got=%0d exp=256", q_period[0]); end
      n_vec++; if (q_t[0] != t0 + 2560 + 30) begin n_err++; $display("FAIL rst_mid.time got=%0t exp=%0t", q_t[0], t0 + 2560 + 30); end
    end
  endtask

  task automatic test_phase();
    int ph;
    for (int k = 0; k < 2; k++) begin
      ph = int'($urandom_range(9));
      clear_q();
      @(negedge clk);
      #(ph);
      for (int c = 0; c < 3; c++) begin
        pwm_in = 1'b1;
        #640;
        pwm_in = 1'b0;
        #1920;
      end
      n_vec++; if (q_duty.size() != 3) begin n_err++; $display("FAIL phase%0d.count got=%0d exp=3", ph, q_duty.size()); end
      for (int i = 1; i < q_duty.size(); i++) begin
        n_vec++; if (q_duty[i] < 16'd63 || q_duty[i] > 16'd65) begin n_err++; $display("FAIL phase%0d.duty got=%0d exp=64+/-1", ph, q_duty[i]); end
        n_vec++; if (q_period[i] < 16'd255 || q_period[i] > 16'd257) begin n_err++; $display("FAIL phase%0d.period got=%0d exp=256+/-1", ph, q_period[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_stuck_low();
    test_stuck_high();
    test_reset_mid();
    test_phase();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 255: nominal PWM period minus one, used for the timeout and saturation values.
REQ-002 SHALL have parameter TIMEOUT, default 2*(MAX_COUNT+1): the number of cycles without an edge that is treated as a static level.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 pwm_in  input  1  PWM waveform, asynchronous to clk.
REQ-006 duty  output  16  measured high time in clk cycles.
REQ-007 period  output  16  measured rising-edge-to-rising-edge time in clk cycles.
REQ-008 valid  output  1  one-cycle pulse marking new duty/period.
REQ-009 stuck  output  2  static-level flag: 00 none, 01 stuck low, 10 stuck high.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer; a third register SHALL hold the previous sample for edge detection.
REQ-011 A rising or falling edge SHALL be detected 3 clk cycles after the input transition.
REQ-012 FSM states SHALL be SYNC, HIGH and LOW.
REQ-013 SYNC: the block SHALL ignore all activity until the first rising edge, then enter HIGH with hi_cnt=1 and lo_cnt=0.
REQ-014 HIGH: hi_cnt SHALL increment every cycle; a falling edge SHALL move the FSM to LOW with lo_cnt=1.
REQ-015 LOW: lo_cnt SHALL increment every cycle.
REQ-016 LOW, on a rising edge: duty<=hi_cnt, period<=hi_cnt+lo_cnt, valid=1 for one cycle (the cycle after edge detect), stuck<=00, then HIGH with hi_cnt=1 and lo_cnt=0.
REQ-017 Counters SHALL be 16 bits and saturate at 0xFFFF, never wrap; period SHALL saturate at 0xFFFF on sum overflow.
REQ-018 Stuck low: lo_cnt (LOW), or idle count (SYNC with the synchronized level low), reaching TIMEOUT SHALL set duty=0, period=0, stuck=01 and pulse valid once.
REQ-019 Stuck high: hi_cnt (HIGH) reaching TIMEOUT SHALL set duty=MAX_COUNT+1, period=0, stuck=10 and pulse valid once.
REQ-020 After a stuck report the FSM SHALL stay in its state, counting saturated, with no further valid pulses until the next edge.
REQ-021 The next rising edge after stuck-low SHALL enter HIGH fresh and SHALL NOT report a measurement.
REQ-022 A falling edge after stuck-high SHALL enter LOW normally, with hi_cnt held saturated.
REQ-023 duty and period SHALL hold their last values between valid pulses.

Reset
REQ-024 rst_n=0 SHALL immediately clear duty, period, valid, stuck, all counters and synchronizer flops, and force the FSM to SYNC.
REQ-025 Reset mid-measurement SHALL discard partial counts; the first valid after release SHALL require one full low-to-high-to-low-to-high cycle.
REQ-026 Reset deassertion SHALL take effect on the next rising clk edge.

Structure
REQ-027 Package pwm_pkg SHALL hold the FSM state typedef (SYNC/HIGH/LOW), CNT_W=16, and the stuck-code constants.
REQ-028 Sub-module sync_2ff SHALL implement the 1-bit 2-flop synchronizer with asynchronous active-low reset.
REQ-029 Counters, FSM and output registers SHALL reside in pwm_decoder.

Verification
REQ-030 Period 256, duty 64, 5 cycles -> from the 2nd rising edge on, each valid gives duty=64, period=256, stuck=00.
REQ-031 Sweep duty 1, 128, 255 at period 256 -> duty equals the programmed value on the 2nd valid after each change; period=256.
REQ-032 pwm_in held low for 600 cycles after lock -> exactly one valid, with duty=0, period=0, stuck=01, at TIMEOUT=512 cycles after the last falling edge.
REQ-033 pwm_in held high for 600 cycles -> exactly one valid, with duty=256, stuck=10; a later normal waveform -> stuck=00 and correct duty.
REQ-034 rst_n pulsed low mid-HIGH -> outputs 0 immediately, no valid until a complete new period, then correct values.
REQ-035 Glitch-free input with random 0-9 ns phase relative to clk -> measured duty within +/-1 of nominal.
